// File: rtl/posit_unary_ops_seq.sv
// Posit unary unit: NEG, ABS, SGN and RNI (ties-to-even) behind valid/ready.
// RNI walks the significand right one bit per cycle before rounding.
package posit_pkg;

    typedef enum logic [1:0] {
        POSIT8_ES1  = 2'd0,
        POSIT16_ES1 = 2'd1,
        POSIT32_ES2 = 2'd2
    } posit_format_e;

    function automatic int posit_width(posit_format_e f);
        case (f)
            POSIT16_ES1: return 16;
            POSIT32_ES2: return 32;
            default:     return 8;
        endcase
    endfunction

    function automatic int exp_bits(posit_format_e f);
        case (f)
            POSIT32_ES2: return 2;
            default:     return 1;
        endcase
    endfunction

endpackage

module posit_unary_ops_seq
    import posit_pkg::*;
#(
    parameter posit_format_e pFormat = posit_format_e'(0),
    parameter int unsigned   TAG_W   = 1,
    localparam int           WIDTH   = posit_width(pFormat),
    localparam int           ES      = exp_bits(pFormat)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] operand_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             nx_o,
    output logic             busy_o
);

    localparam int W  = WIDTH;
    localparam int F  = W - 3 - ES;
    localparam int CW = $clog2(F + 1);

    localparam logic [1:0] OP_NEG = 2'b00;
    localparam logic [1:0] OP_ABS = 2'b01;
    localparam logic [1:0] OP_SGN = 2'b10;
    localparam logic [1:0] OP_RNI = 2'b11;

    localparam logic [W-1:0] NAR  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONE  = {2'b01, {(W-2){1'b0}}};
    localparam logic [W-1:0] MONE = {2'b11, {(W-2){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_SHIFT,
        S_ROUND,
        S_DONE
    } state_e;

    state_e           r_state;
    state_e           w_next;

    logic [W-1:0]     r_opnd;
    logic [TAG_W-1:0] r_tag;
    logic             r_sign;
    logic [F:0]       r_sig;
    logic             r_guard;
    logic             r_sticky;
    logic [CW-1:0]    r_cnt;
    logic [W-1:0]     r_result;
    logic [TAG_W-1:0] r_tag_o;
    logic             r_nx;

    // ---- accept-time results for the single-cycle ops
    logic [W-1:0] w_neg;
    logic [W-1:0] w_unary;
    logic         w_in_zero;
    logic         w_in_nar;

    assign w_neg     = -operand_i;
    assign w_in_zero = (operand_i == '0);
    assign w_in_nar  = (operand_i == NAR);

    always_comb begin
        w_unary = operand_i;
        unique case (op_i)
            OP_NEG: w_unary = w_neg;
            OP_ABS: w_unary = operand_i[W-1] ? w_neg : operand_i;
            OP_SGN: begin
                if (w_in_zero || w_in_nar)
                    w_unary = operand_i;
                else
                    w_unary = operand_i[W-1] ? MONE : ONE;
            end
            OP_RNI: w_unary = operand_i;
        endcase
    end

    // ---- RNI decode of the registered operand
    logic          w_zero;
    logic          w_nar;
    logic [W-2:0]  w_body;
    logic [W-4:0]  w_rem;
    logic [ES-1:0] w_exp;
    logic [F-1:0]  w_frac;
    logic          w_go;
    int            w_run;
    int            w_k;
    int            w_s;
    logic [CW-1:0] w_n;
    logic          w_half;
    logic          w_short;

    assign w_zero = (r_opnd == '0);
    assign w_nar  = (r_opnd == NAR);
    assign w_body = (r_opnd[W-2:0] ^ {(W-1){r_opnd[W-1]}})
                  + {{(W-2){1'b0}}, r_opnd[W-1]};

    always_comb begin
        w_run = 0;
        w_go  = 1'b1;
        for (int i = W - 2; i >= 0; i--) begin
            if (w_go && (w_body[i] == w_body[W-2]))
                w_run = w_run + 1;
            else
                w_go = 1'b0;
        end
        w_k = w_body[W-2] ? (w_run - 1) : -w_run;
        // the top two body bits are always regime, so skip them here
        w_rem  = w_body[W-4:0] << (w_run - 1);
        w_exp  = w_rem[W-4 -: ES];
        w_frac = w_rem[F-1:0];
        w_s    = w_k * (2 ** ES) + int'(w_exp);
        w_n    = CW'(F - w_s);
    end

    assign w_half  = (w_s == -1) && (w_frac == '0);
    assign w_short = w_zero || w_nar || (w_s >= F) || (w_s <= -1);

    // ---- RNI round and re-encode
    logic          w_rup;
    logic [F:0]    w_int;
    int            w_p;
    int            w_k2;
    logic [ES-1:0] w_e2;
    logic [F-1:0]  w_frac2;
    logic [W-4:0]  w_ef;
    logic [W-2:0]  w_reg;
    logic [W-2:0]  w_body2;
    logic [W-1:0]  w_mag;
    logic [W-1:0]  w_enc;

    assign w_rup = r_guard & (r_sticky | r_sig[0]);
    assign w_int = r_sig + {{F{1'b0}}, w_rup};

    always_comb begin
        w_p = 0;
        for (int i = 0; i <= F; i++) begin
            if (w_int[i])
                w_p = i;
        end
        w_k2    = w_p >> ES;
        w_e2    = w_p[ES-1:0];
        w_frac2 = w_int[F-1:0] << (F - w_p);
        w_ef    = {w_e2, w_frac2};
        w_reg   = ~({(W-1){1'b1}} >> (w_k2 + 1));
        w_body2 = w_reg | ({w_ef, 2'b00} >> (w_k2 + 2));
        w_mag   = {1'b0, w_body2};
        w_enc   = r_sign ? -w_mag : w_mag;
    end

    // ---- FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush_i) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid_i)
                        w_next = (op_i == OP_RNI) ? S_DECODE : S_DONE;
                end
                S_DECODE: w_next = w_short ? S_DONE : S_SHIFT;
                S_SHIFT: begin
                    if (r_cnt == CW'(1))
                        w_next = S_ROUND;
                end
                S_ROUND: w_next = S_DONE;
                S_DONE: begin
                    if (out_ready_i)
                        w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready_o  = (r_state == S_IDLE);
        busy_o      = (r_state != S_IDLE);
        out_valid_o = (r_state == S_DONE);
    end

    // ---- datapath
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_opnd   <= '0;
            r_tag    <= '0;
            r_sign   <= 1'b0;
            r_sig    <= '0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_tag_o  <= '0;
            r_nx     <= 1'b0;
        end else if (!flush_i) begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_opnd <= operand_i;
                        r_tag  <= tag_i;
                        if (op_i != OP_RNI) begin
                            r_result <= w_unary;
                            r_tag_o  <= tag_i;
                            r_nx     <= 1'b0;
                        end
                    end
                end
                S_DECODE: begin
                    r_sign   <= r_opnd[W-1];
                    r_sig    <= {1'b1, w_frac};
                    r_guard  <= 1'b0;
                    r_sticky <= 1'b0;
                    r_cnt    <= w_n;
                    if (w_zero || w_nar || (w_s >= F)) begin
                        r_result <= r_opnd;
                        r_tag_o  <= r_tag;
                        r_nx     <= 1'b0;
                    end else if (w_s <= -2) begin
                        r_result <= '0;
                        r_tag_o  <= r_tag;
                        r_nx     <= 1'b1;
                    end else if (w_s == -1) begin
                        r_result <= w_half ? '0
                                  : (r_opnd[W-1] ? MONE : ONE);
                        r_tag_o  <= r_tag;
                        r_nx     <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_sig    <= r_sig >> 1;
                    r_guard  <= r_sig[0];
                    r_sticky <= r_sticky | r_guard;
                    r_cnt    <= r_cnt - CW'(1);
                end
                S_ROUND: begin
                    r_result <= w_enc;
                    r_tag_o  <= r_tag;
                    r_nx     <= r_guard | r_sticky;
                end
                S_DONE: ;
                default: ;
            endcase
        end
    end

    assign result_o = r_result;
    assign tag_o    = r_tag_o;
    assign nx_o     = r_nx;

endmodule

// File: tb/tb_posit_unary_ops_seq.sv
// Bench for posit_unary_ops_seq (posit8, es=1): scoreboard fed by a
// real-valued posit model, plus directed, backpressure, flush and reset cases.
module tb_posit_unary_ops_seq;

    localparam int W  = 8;
    localparam int ES = 1;
    localparam int F  = W - 3 - ES;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [W-1:0]  operand;
    logic [TW-1:0] tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [TW-1:0] tag_o;
    logic          nx;
    logic          busy;

    posit_unary_ops_seq #(
        .pFormat(posit_pkg::POSIT8_ES1),
        .TAG_W  (TW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .op_i       (op),
        .operand_i  (operand),
        .tag_i      (tag),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .tag_o      (tag_o),
        .nx_o       (nx),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  x;
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
        logic          nx;
        int            lat;
        int            c0;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    bit   seen = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    real  tbl[256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    // posit value from the definition: sign, regime run, exponent, fraction
    function automatic real pdec(input int c);
        int  a, i, m, k, e, r0;
        real f, wt, v;
        if (c == 0 || c == 128) return 0.0;
        a  = (c >= 128) ? 256 - c : c;
        r0 = (a >> 6) & 1;
        m  = 0;
        i  = 6;
        while (i >= 0 && ((a >> i) & 1) == r0) begin
            m++;
            i--;
        end
        k = r0 ? m - 1 : -m;
        i--;
        e = 0;
        for (int j = 0; j < ES; j++) begin
            e = e * 2 + ((i >= 0) ? ((a >> i) & 1) : 0);
            i--;
        end
        f  = 1.0;
        wt = 0.5;
        while (i >= 0) begin
            if (((a >> i) & 1) == 1) f = f + wt;
            wt = wt / 2.0;
            i--;
        end
        v = f * (2.0 ** real'(k * (2 ** ES) + e));
        return (c >= 128) ? -v : v;
    endfunction

    function automatic logic [W-1:0] find(input real v);
        for (int i = 0; i < 256; i++)
            if (i != 128 && tbl[i] == v) return W'(i);
        return 8'h80;
    endfunction

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x,
                                   input logic [TW-1:0] t, input int c0);
        exp_t e;
        real  v, a, fl, d, r;
        int   s;
        e.op = o; e.x = x; e.tag = t; e.c0 = c0; e.nx = 1'b0; e.lat = 1;
        v = tbl[x];
        if (x == 8'h80) begin
            e.res = 8'h80;
            if (o == 2'd3) e.lat = 2;
            return e;
        end
        case (o)
            2'd0: e.res = find(-v);
            2'd1: e.res = find((v < 0.0) ? -v : v);
            2'd2: e.res = (v == 0.0) ? 8'h00 : find((v > 0.0) ? 1.0 : -1.0);
            default: begin
                e.lat = 2;
                if (v == 0.0) begin
                    e.res = 8'h00;
                end else begin
                    a = (v < 0.0) ? -v : v;
                    s = 0;
                    r = a;
                    while (r >= 2.0) begin r = r / 2.0; s++; end
                    while (r < 1.0) begin r = r * 2.0; s--; end
                    fl = $floor(a);
                    d  = a - fl;
                    r  = fl;
                    if (d > 0.5 || (d == 0.5 && ($rtoi(fl) % 2) == 1))
                        r = fl + 1.0;
                    e.nx  = (d != 0.0);
                    e.res = find((v < 0.0) ? -r : r);
                    if (s >= 0 && s < F) e.lat = 3 + F - s;
                end
            end
        endcase
        return e;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [TW-1:0] t, output int c0);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready %0b, expected 1", in_ready);
        end
        in_valid = 1'b1;
        op       = o;
        operand  = x;
        tag      = t;
        c0       = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d pending, expected 0", q.size());
            q.delete();
        end
    endtask

    // monitor: compare every valid cycle; pop on handshake
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: result %0h, expected none",
                         result);
            end else begin
                mon_e = q[0];
                if (!seen) begin
                    chk($sformatf("latency op%0d x%0h", mon_e.op, mon_e.x),
                        cyc - mon_e.c0, mon_e.lat);
                    chk("ready_busy_in_done", {in_ready, busy}, 2'b01);
                    seen = 1'b1;
                end
                chk($sformatf("result op%0d x%0h", mon_e.op, mon_e.x),
                    result, mon_e.res);
                chk($sformatf("tag op%0d x%0h", mon_e.op, mon_e.x),
                    tag_o, mon_e.tag);
                chk($sformatf("nx op%0d x%0h", mon_e.op, mon_e.x),
                    nx, mon_e.nx);
                if (out_ready && !flush) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] res;
        logic         nx;
        int           lat;
    } vec_t;

    vec_t dv[$];
    exp_t ex;
    int   c0;
    bit   done;

    initial begin
        for (int i = 0; i < 256; i++) tbl[i] = pdec(i);
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; operand = '0; tag = '0;

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_tag", tag_o, 0);
        chk("rst_nx", nx, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);

        dv.push_back('{2'd0, 8'h48, 8'hB8, 1'b0, 1});
        dv.push_back('{2'd0, 8'h80, 8'h80, 1'b0, 1});
        dv.push_back('{2'd0, 8'h00, 8'h00, 1'b0, 1});
        dv.push_back('{2'd1, 8'hB8, 8'h48, 1'b0, 1});
        dv.push_back('{2'd2, 8'hB8, 8'hC0, 1'b0, 1});
        dv.push_back('{2'd2, 8'h30, 8'h40, 1'b0, 1});
        dv.push_back('{2'd2, 8'h00, 8'h00, 1'b0, 1});
        dv.push_back('{2'd3, 8'h54, 8'h50, 1'b1, 6});
        dv.push_back('{2'd3, 8'h48, 8'h50, 1'b1, 7});
        dv.push_back('{2'd3, 8'hB8, 8'hB0, 1'b1, 7});
        dv.push_back('{2'd3, 8'h30, 8'h00, 1'b1, 2});
        dv.push_back('{2'd3, 8'h40, 8'h40, 1'b0, 7});
        dv.push_back('{2'd3, 8'h80, 8'h80, 1'b0, 2});
        dv.push_back('{2'd3, 8'hD8, 8'h00, 1'b1, 2});
        foreach (dv[i]) begin
            issue(dv[i].op, dv[i].x, TW'(i), c0);
            q.push_back('{dv[i].op, dv[i].x, dv[i].res, TW'(i),
                          dv[i].nx, dv[i].lat, c0});
            drain();
        end

        // backpressure
        out_ready = 1'b0;
        issue(2'd1, 8'hB8, 3'd5, c0);
        q.push_back(model(2'd1, 8'hB8, 3'd5, c0));
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // flush in the middle of SHIFT
        issue(2'd3, 8'h48, 3'd2, c0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 flush = 1'b1;
        chk("flush_busy_before", busy, 1);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_valid", out_valid, 0);
        chk("flush_result_kept", result, 8'h48);
        chk("flush_tag_kept", tag_o, 3'd5);
        repeat (6) @(negedge clk);
        chk("flush_valid_later", out_valid, 0);

        // async reset during SHIFT
        issue(2'd3, 8'h54, 3'd6, c0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_result", result, 0);
        chk("arst_tag", tag_o, 0);
        chk("arst_nx", nx, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(2'd3, 8'h48, 3'd7, c0);
        q.push_back('{2'd3, 8'h48, 8'h50, 3'd7, 1'b1, 7, c0});
        drain();

        // randomized traffic with random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [1:0]    ro;
                    logic [W-1:0]  rx;
                    logic [TW-1:0] rt;
                    ro = 2'($urandom_range(0, 3));
                    rx = 8'($urandom_range(0, 255));
                    rt = TW'($urandom_range(0, 7));
                    issue(ro, rx, rt, c0);
                    q.push_back(model(ro, rx, rt, c0));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                drain();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
